seq_tx0101: RTL and testbench

Serial bit-string transmitter that drives the input of the 0101 string-recognition detector. The transmitter loads a parallel word and a bit length, then shifts the active bits out MSB-first, one bit per enabled cycle, with a valid qualifier. It also counts the 0101 occurrences it emits, using the detector's restart-after-match rule, so a bench can compare its own count against the detector's pulses. The block sits between the stimulus or control logic and the detector in the string-recognition datapath.

---
 rtl/seq_tx0101.sv | 137 +++++++++++++
 tb/tb_seq_tx0101.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_tx0101.sv
// Serial transmitter for the 0101 recognizer: loads a word, shifts len bits out MSB-first
// with a valid qualifier, and counts emitted 0101 matches using restart-after-match.
//
// state | meaning
// IDLE  | ready, waiting for a legal load
// SHIFT | emitting frame bits; remaining==0 means the last bit is on the wire
// FIN   | one-cycle done pulse; a legal load here starts the next frame
module seq_tx0101 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic [CNT_W-1:0] len_in,
   input  logic             stall,
   output logic             ready,
   output logic             seq_out,
   output logic             seq_valid,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FIN} state_t;
   typedef enum logic [1:0] {T_S0, T_S1, T_S2, T_S3} trk_t;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

   state_t           state, state_n;
   trk_t             trk, trk_n, trk_base;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CNT_W-1:0] remaining, remaining_n;
   logic [CNT_W-1:0] cnt_n, cnt_base;
   logic             ready_n, seq_out_n, seq_valid_n, done_n;
   logic             emit, emit_bit;
   logic             len_ok;
   logic [CNT_W-1:0] shamt;
   logic [WIDTH-1:0] aligned;

   assign len_ok  = (len_in != '0) && (len_in <= WIDTH_C);
   assign shamt   = WIDTH_C - len_in;
   assign aligned = data_in << shamt;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         trk       <= T_S0;
         shreg     <= '0;
         remaining <= '0;
         ready     <= 1'b1;
         seq_out   <= 1'b0;
         seq_valid <= 1'b0;
         done      <= 1'b0;
         match_cnt <= '0;
      end else begin
         state     <= state_n;
         trk       <= trk_n;
         shreg     <= shreg_n;
         remaining <= remaining_n;
         ready     <= ready_n;
         seq_out   <= seq_out_n;
         seq_valid <= seq_valid_n;
         done      <= done_n;
         match_cnt <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      remaining_n = remaining;
      trk_base    = trk;
      cnt_base    = match_cnt;
      ready_n     = 1'b0;
      done_n      = 1'b0;
      emit        = 1'b0;
      emit_bit    = 1'b0;

      case (state)
         ST_IDLE, ST_FIN: begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            // The accepting edge already presents the first bit, so it is valid next cycle.
            if (load && len_ok) begin
               state_n     = ST_SHIFT;
               ready_n     = 1'b0;
               emit        = 1'b1;
               emit_bit    = aligned[WIDTH-1];
               shreg_n     = aligned << 1;
               remaining_n = len_in - CNT_W'(1);
               trk_base    = T_S0;
               cnt_base    = '0;
            end
         end
         ST_SHIFT: begin
            if (remaining == '0) begin
               state_n = ST_FIN;
               done_n  = 1'b1;
               ready_n = 1'b1;
            end else if (!stall) begin
               emit        = 1'b1;
               emit_bit    = shreg[WIDTH-1];
               shreg_n     = shreg << 1;
               remaining_n = remaining - CNT_W'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
         end
      endcase

      trk_n       = trk_base;
      cnt_n       = cnt_base;
      seq_valid_n = emit;
      seq_out_n   = emit & emit_bit;
      if (emit) begin
         case (trk_base)
            T_S0: trk_n = emit_bit ? T_S0 : T_S1;
            T_S1: trk_n = emit_bit ? T_S2 : T_S1;
            T_S2: trk_n = emit_bit ? T_S0 : T_S3;
            T_S3: begin
               // Completed match: restart from scratch so the tail is never reused.
               if (emit_bit) begin
                  trk_n = T_S0;
                  cnt_n = cnt_base + CNT_W'(1);
               end else begin
                  trk_n = T_S1;
               end
            end
            default: trk_n = T_S0;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_tx0101.sv
// Directed bench for seq_tx0101: expected bits are queued at load time and popped as
// seq_valid bits arrive; frame timing and match counts come from an independent scan model.
module tb_seq_tx0101;

   logic        clock = 1'b0;
   logic        reset, load, stall;
   logic [15:0] data_in;
   logic [4:0]  len_in;
   logic        ready, seq_out, seq_valid, done;
   logic [4:0]  match_cnt;

   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   logic exp_q[$];

   seq_tx0101 #(.WIDTH(16), .CNT_W(5)) dut (
      .clock(clock), .reset(reset), .load(load), .data_in(data_in), .len_in(len_in),
      .stall(stall), .ready(ready), .seq_out(seq_out), .seq_valid(seq_valid),
      .done(done), .match_cnt(match_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leftmost scan that skips past each match, independent of the suffix tracker.
   function automatic int model_matches(input logic [15:0] d, input int len);
      logic bits [16];
      int   cnt = 0;
      int   i = 0;
      for (int k = 0; k < len; k++) bits[k] = d[len-1-k];
      while (i + 3 < len) begin
         if (!bits[i] && bits[i+1] && !bits[i+2] && bits[i+3]) begin
            cnt++;
            i += 4;
         end else begin
            i++;
         end
      end
      return cnt;
   endfunction

   task automatic tick();
      logic b;
      @(posedge clock);
      #1;
      if (done === 1'b1) done_cnt++;
      if (seq_valid === 1'b1) begin
         check("bits_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("bit", 32'(seq_out), 32'(b));
         end
      end else begin
         check("idle_out", 32'(seq_out), 32'd0);
      end
   endtask

   task automatic run_frame(input logic [15:0] d, input int len, input int st_after,
                            input int st_n);
      int bits = 0;
      int cyc = 1;
      int nst = 0;
      for (int k = len - 1; k >= 0; k--) exp_q.push_back(d[k]);
      load = 1'b1; data_in = d; len_in = 5'(len); stall = 1'b0;
      tick();
      load = 1'b0;
      check("first_valid", 32'(seq_valid), 32'd1);
      check("mc_clear", 32'(match_cnt), 32'd0);
      if (seq_valid === 1'b1) bits = 1;
      while (done !== 1'b1 && cyc < 60) begin
         if (bits == st_after && nst < st_n) begin
            stall = 1'b1;
            nst++;
         end else begin
            stall = 1'b0;
         end
         tick();
         cyc++;
         if (seq_valid === 1'b1) bits++;
      end
      stall = 1'b0;
      check("done_seen", 32'(done), 32'd1);
      check("done_cycle", 32'(cyc), 32'(len + 1 + st_n));
      check("bit_count", 32'(bits), 32'(len));
      check("match_cnt", 32'(match_cnt), 32'(model_matches(d, len)));
      check("ready_fin", 32'(ready), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int dc;
      reset = 1'b1; load = 1'b0; stall = 1'b0; data_in = '0; len_in = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(seq_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mc", 32'(match_cnt), 32'd0);
      tick();

      run_frame(16'h0005, 4, -1, 0);
      tick();
      check("idle_after_fin", 32'(ready), 32'd1);
      run_frame(16'h002A, 7, -1, 0);
      tick();
      run_frame(16'h0055, 8, -1, 0);
      tick();
      run_frame(16'h0005, 4, 2, 2);
      tick();
      run_frame(16'h5555, 16, -1, 0);
      tick();
      run_frame(16'h0001, 1, -1, 0);
      tick();
      tick();
      check("mc_hold", 32'(match_cnt), 32'd0);

      // Back-to-back: the second load lands in the FIN cycle of the first frame.
      run_frame(16'h0055, 8, -1, 0);
      run_frame(16'h0005, 4, -1, 0);
      tick();

      dc = done_cnt;
      load = 1'b1; data_in = 16'h0005; len_in = 5'd0;
      tick();
      check("len0_valid", 32'(seq_valid), 32'd0);
      check("len0_ready", 32'(ready), 32'd1);
      len_in = 5'd17;
      tick();
      check("len17_valid", 32'(seq_valid), 32'd0);
      check("len17_ready", 32'(ready), 32'd1);
      load = 1'b0;
      tick();
      tick();
      check("bad_len_no_done", 32'(done_cnt), 32'(dc));

      // Reset after 3 of 8 bits aborts without a done pulse.
      for (int k = 7; k >= 0; k--) exp_q.push_back(data_in[k] & 1'b0 | 8'h55 >> k & 1'b1);
      load = 1'b1; data_in = 16'h0055; len_in = 5'd8;
      tick();
      load = 1'b0;
      tick();
      tick();
      check("pre_rst_valid", 32'(seq_valid), 32'd1);
      dc = done_cnt;
      reset = 1'b1;
      tick();
      exp_q.delete();
      check("abort_valid", 32'(seq_valid), 32'd0);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_mc", 32'(match_cnt), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      check("abort_no_done", 32'(done_cnt), 32'(dc));
      check("abort_idle_ready", 32'(ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
